arcade_input_hub: RTL and testbench

- Parametrised successor to the per-core input/DIP glue in the arcade top levels.
- Decodes PS/2 key events and merges them with N MiSTer joysticks.
- Handles upright/cocktail control sharing, stretches coin pulses over a set number of frames, and captures DIP/SYSMODE bytes from the ioctl stream.
- Sits between hps_io and the game core and drives the core's active-low INPx/DSWx buses.

---
 rtl/arcade_input_pkg.sv | 76 +++++++
 rtl/coin_stretch.sv | 46 ++++
 rtl/arcade_input_hub.sv | 226 ++++++++++++++++++++++
 tb/tb_arcade_input_hub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and helpers for the arcade input hub: joystick bit map,
// PS/2 set-2 scancodes and the active-low player byte layout.
package arcade_input_pkg;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_TRIG1  = 4;
    localparam int unsigned JOY_TRIG2  = 5;
    localparam int unsigned JOY_TRIG3  = 6;
    localparam int unsigned JOY_START1 = 7;
    localparam int unsigned JOY_START2 = 8;
    localparam int unsigned JOY_COIN   = 9;
    localparam int unsigned JOY_USED   = 10;

    // Low byte only; arrows, ctrl and alt match with or without the E0 prefix.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_ALT   = 8'h11;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_Q     = 8'h15;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic trig1;
        logic trig2;
        logic trig3;
    } player_ctl_t;

    typedef struct packed {
        player_ctl_t p1;
        player_ctl_t p2;
        logic        start1;
        logic        start2;
        logic        coin1;
        logic        coin2;
        logic        f1;
        logic        f2;
    } kbd_state_t;

    function automatic player_ctl_t joy_to_ctl(input logic [JOY_USED-1:0] j);
        player_ctl_t c;
        c.up    = j[JOY_UP];
        c.down  = j[JOY_DOWN];
        c.left  = j[JOY_LEFT];
        c.right = j[JOY_RIGHT];
        c.trig1 = j[JOY_TRIG1];
        c.trig2 = j[JOY_TRIG2];
        c.trig3 = j[JOY_TRIG3];
        return c;
    endfunction

    function automatic logic [7:0] player_byte(input player_ctl_t c);
        return ~{c.left, c.right, c.up, c.down, 1'b0, c.trig2, c.trig1, c.trig3};
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// Holds a coin line asserted for at least COIN_FRAMES vblank rising edges
// after each rising edge of the raw coin input.
module coin_stretch #(
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic coin_raw,
    input  logic vblank,
    output logic coin_out
);

    logic [3:0] cnt_q, cnt_d;
    logic       coin_prev_q;
    logic       vblank_prev_q;
    logic       coin_rise;
    logic       vblank_rise;

    assign coin_rise   = coin_raw & ~coin_prev_q;
    assign vblank_rise = vblank & ~vblank_prev_q;

    // A new coin edge reloads even when a frame edge lands in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (coin_rise) begin
            cnt_d = 4'(COIN_FRAMES);
        end else if (vblank_rise && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q         <= 4'd0;
            coin_prev_q   <= 1'b0;
            vblank_prev_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            coin_prev_q   <= coin_raw;
            vblank_prev_q <= vblank;
        end
    end

    assign coin_out = coin_raw | (cnt_q != 4'd0);

endmodule

// File: rtl/arcade_input_hub.sv
// Merges PS/2 keys and MiSTer joysticks into the core's active-low input buses
// and captures DIP / system-mode bytes from the ioctl download stream.
module arcade_input_hub
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned DSW_BYTES     = 8,
    parameter int unsigned DSW_INDEX     = 254,
    parameter int unsigned MODE_INDEX    = 1,
    parameter int unsigned COIN_FRAMES   = 3,
    parameter int unsigned COIN_SEPARATE = 0
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joystick,
    input  logic                      cocktail,
    input  logic                      vblank,
    input  logic                      ioctl_wr,
    input  logic [7:0]                ioctl_index,
    input  logic [24:0]               ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    output logic [8*NUM_PLAYERS-1:0]  inp_player,
    output logic [7:0]                inp_sys,
    output logic [8*DSW_BYTES-1:0]    dsw,
    output logic [7:0]                sysmode
);

    // Keyboard P2 always exists internally, so at least two player slots.
    localparam int unsigned NP = (NUM_PLAYERS < 2) ? 2 : NUM_PLAYERS;

    // ---------------------------------------------------------------- PS/2
    kbd_state_t key_q, key_d;
    logic       ps2_tog_q;
    logic       ps2_event;
    logic       pressed;

    assign ps2_event = ps2_key[10] != ps2_tog_q;
    assign pressed   = ps2_key[9];

    always_comb begin
        key_d = key_q;
        if (ps2_event) begin
            case (ps2_key[7:0])
                SC_UP:    key_d.p1.up    = pressed;
                SC_DOWN:  key_d.p1.down  = pressed;
                SC_LEFT:  key_d.p1.left  = pressed;
                SC_RIGHT: key_d.p1.right = pressed;
                SC_CTRL:  key_d.p1.trig2 = pressed;
                SC_ALT:   key_d.p1.trig3 = pressed;
                default:  ;
            endcase
            if (!ps2_key[8]) begin
                case (ps2_key[7:0])
                    SC_SPACE: key_d.p1.trig1 = pressed;
                    SC_F1:    key_d.f1       = pressed;
                    SC_F2:    key_d.f2       = pressed;
                    SC_1:     key_d.start1   = pressed;
                    SC_2:     key_d.start2   = pressed;
                    SC_5:     key_d.coin1    = pressed;
                    SC_6:     key_d.coin2    = pressed;
                    SC_R:     key_d.p2.up    = pressed;
                    SC_F:     key_d.p2.down  = pressed;
                    SC_D:     key_d.p2.left  = pressed;
                    SC_G:     key_d.p2.right = pressed;
                    SC_A:     key_d.p2.trig1 = pressed;
                    SC_S:     key_d.p2.trig2 = pressed;
                    SC_Q:     key_d.p2.trig3 = pressed;
                    default:  ;
                endcase
            end
        end
    end

    // The toggle is tracked through reset so a stale event is not replayed.
    always_ff @(posedge clk_sys) begin
        ps2_tog_q <= ps2_key[10];
        if (reset) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    // ----------------------------------------------------------- joysticks
    logic [16*NP-1:0]    joy_pad;
    logic [JOY_USED-1:0] joy_q [NP];
    logic                unused_joy;

    assign joy_pad = (16*NP)'(joystick);

    always_comb begin
        unused_joy = 1'b0;
        for (int p = 0; p < NP; p++) begin
            unused_joy = unused_joy ^ (^joy_pad[16*p+JOY_USED +: 16-JOY_USED]);
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < NP; p++) begin
            if (reset) begin
                joy_q[p] <= '0;
            end else begin
                joy_q[p] <= joy_pad[16*p +: JOY_USED];
            end
        end
    end

    // --------------------------------------------------------------- merge
    player_ctl_t ctl [NP];
    logic        start1;
    logic        start2;
    logic        coin_a_raw;
    logic        coin_b_raw;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            ctl[p] = joy_to_ctl(joy_q[p]);
        end
        ctl[0] = ctl[0] | key_q.p1;
        ctl[1] = ctl[1] | key_q.p2;
        if (!cocktail) begin
            for (int p = 1; p < NP; p++) begin
                ctl[0] = ctl[0] | ctl[p];
            end
        end

        start1     = key_q.start1 | key_q.f1;
        start2     = key_q.start2 | key_q.f2;
        coin_a_raw = key_q.coin1 | key_q.f1;
        coin_b_raw = key_q.coin2 | key_q.f2;
        for (int p = 0; p < NP; p++) begin
            start1 = start1 | joy_q[p][JOY_START1];
            start2 = start2 | joy_q[p][JOY_START2];
            if (p % 2 == 0) begin
                coin_a_raw = coin_a_raw | joy_q[p][JOY_COIN];
            end else begin
                coin_b_raw = coin_b_raw | joy_q[p][JOY_COIN];
            end
        end
    end

    // -------------------------------------------------------------- coins
    logic coin_a;
    logic coin_b;

    coin_stretch #(
        .COIN_FRAMES (COIN_FRAMES)
    ) u_coin_a (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .coin_raw (coin_a_raw),
        .vblank   (vblank),
        .coin_out (coin_a)
    );

    coin_stretch #(
        .COIN_FRAMES (COIN_FRAMES)
    ) u_coin_b (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .coin_raw (coin_b_raw),
        .vblank   (vblank),
        .coin_out (coin_b)
    );

    // ------------------------------------------------------------ outputs
    logic [8*NUM_PLAYERS-1:0] inp_player_q, inp_player_d;
    logic [7:0]               inp_sys_q, inp_sys_d;
    logic                     coin_lo;
    logic                     coin_hi;

    always_comb begin
        inp_player_d = '1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            inp_player_d[8*p +: 8] = player_byte(ctl[p]);
        end
        if (COIN_SEPARATE != 0) begin
            coin_lo = coin_a;
            coin_hi = coin_b;
        end else begin
            coin_lo = coin_a | coin_b;
            coin_hi = 1'b0;
        end
        inp_sys_d = ~{2'b00, start2, start1, 2'b00, coin_hi, coin_lo};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            inp_player_q <= '1;
            inp_sys_q    <= '1;
        end else begin
            inp_player_q <= inp_player_d;
            inp_sys_q    <= inp_sys_d;
        end
    end

    assign inp_player = inp_player_q;
    assign inp_sys    = inp_sys_q;

    // -------------------------------------------------------- ioctl capture
    // Deliberately outside reset: DIP settings must survive a core reset.
    logic [8*DSW_BYTES-1:0] dsw_q     = '1;
    logic [7:0]             sysmode_q = 8'h00;
    logic                   dsw_we;
    logic                   mode_we;

    assign dsw_we  = ioctl_wr && (ioctl_index == 8'(DSW_INDEX))
                     && (ioctl_addr < 25'(DSW_BYTES));
    assign mode_we = ioctl_wr && (ioctl_index == 8'(MODE_INDEX)) && (ioctl_addr == 25'd0);

    always_ff @(posedge clk_sys) begin
        for (int n = 0; n < DSW_BYTES; n++) begin
            if (dsw_we && ioctl_addr == 25'(n)) begin
                dsw_q[8*n +: 8] <= ioctl_dout;
            end
        end
        if (mode_we) begin
            sysmode_q <= ioctl_dout;
        end
    end

    assign dsw     = dsw_q;
    assign sysmode = sysmode_q;

endmodule

// File: tb/tb_arcade_input_hub.sv
// Directed bench for arcade_input_hub: keys, joysticks, cocktail sharing,
// coin stretching, ioctl capture and reset behaviour.
module tb_arcade_input_hub;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joystick;
    logic        cocktail;
    logic        vblank;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] inp_player;
    logic [7:0]  inp_sys;
    logic [63:0] dsw;
    logic [7:0]  sysmode;

    int n_checks = 0;
    int n_fail   = 0;
    logic tog = 1'b0;

    arcade_input_hub #(
        .NUM_PLAYERS   (2),
        .DSW_BYTES     (8),
        .DSW_INDEX     (254),
        .MODE_INDEX    (1),
        .COIN_FRAMES   (3),
        .COIN_SEPARATE (0)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .joystick    (joystick),
        .cocktail    (cocktail),
        .vblank      (vblank),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .inp_player  (inp_player),
        .inp_sys     (inp_sys),
        .dsw         (dsw),
        .sysmode     (sysmode)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2(input logic prs, input logic [8:0] code);
        tog = ~tog;
        ps2_key = {tog, prs, code};
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick(1);
        vblank = 1'b0;
        tick(1);
    endtask

    task automatic coin_pulse();
        joystick[9] = 1'b1;
        tick(1);
        joystick[9] = 1'b0;
        tick(2);
    endtask

    task automatic io_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = d;
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ps2_key = '0;
        joystick = '0;
        cocktail = 1'b0;
        vblank = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_index = '0;
        ioctl_addr = '0;
        ioctl_dout = '0;

        tick(2);
        chk("reset_player", inp_player, 16'hFFFF);
        chk("reset_sys", inp_sys, 8'hFF);
        chk("powerup_sysmode", sysmode, 8'h00);
        chk("powerup_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b0;
        tick(2);
        chk("idle_player", inp_player, 16'hFFFF);
        chk("idle_sys", inp_sys, 8'hFF);

        // Space press: trig1 on P1, visible two cycles after the toggle.
        ps2(1'b1, 9'h029);
        tick(1);
        chk("space_lat1", inp_player[7:0], 8'hFF);
        tick(1);
        chk("space_press", inp_player[7:0], 8'hFD);
        ps2(1'b0, 9'h029);
        tick(2);
        chk("space_release", inp_player[7:0], 8'hFF);
        ps2_key = {tog, 1'b1, 9'h029};
        tick(3);
        chk("no_toggle", inp_player[7:0], 8'hFF);

        ps2(1'b1, 9'h175);
        tick(2);
        chk("ext_up", inp_player, 16'hFFDF);
        ps2(1'b1, 9'h0AA);
        tick(2);
        chk("unknown_code", inp_player, 16'hFFDF);
        ps2(1'b0, 9'h175);
        tick(2);
        chk("ext_up_rel", inp_player, 16'hFFFF);

        // P2 keyboard up shares onto P1 in upright mode.
        ps2(1'b1, 9'h02D);
        tick(2);
        chk("p2_key_r", inp_player, 16'hDFDF);
        ps2(1'b0, 9'h02D);
        tick(2);

        joystick[19] = 1'b1;
        tick(2);
        chk("joy_p2_up_upright", inp_player, 16'hDFDF);
        cocktail = 1'b1;
        tick(2);
        chk("joy_p2_up_cocktail", inp_player, 16'hDFFF);
        joystick = '0;
        cocktail = 1'b0;
        joystick[7] = 1'b1;
        tick(2);
        chk("start1", inp_sys, 8'hEF);
        joystick[7] = 1'b0;
        joystick[24] = 1'b1;
        tick(2);
        chk("start2_from_p2", inp_sys, 8'hDF);
        joystick = '0;
        tick(2);

        // Coin stretch across three frames.
        coin_pulse();
        chk("coin_asserted", inp_sys, 8'hFE);
        vb_pulse();
        vb_pulse();
        chk("coin_after_2vb", inp_sys, 8'hFE);
        vb_pulse();
        chk("coin_after_3vb", inp_sys, 8'hFF);

        // Reload when the coin edge coincides with a vblank edge.
        coin_pulse();
        vb_pulse();
        vb_pulse();
        chk("coin2_after_2vb", inp_sys, 8'hFE);
        joystick[9] = 1'b1;
        tick(1);
        joystick[9] = 1'b0;
        vblank = 1'b1;
        tick(1);
        vblank = 1'b0;
        tick(1);
        vb_pulse();
        vb_pulse();
        chk("coin_reload_2vb", inp_sys, 8'hFE);
        vb_pulse();
        chk("coin_reload_3vb", inp_sys, 8'hFF);

        // ioctl capture.
        for (int i = 0; i < 8; i++) begin
            io_write(8'd254, 25'(i), 8'(8'h10 + i));
        end
        io_write(8'd254, 25'd8, 8'hAA);
        io_write(8'd254, 25'h100000, 8'hBB);
        chk("dsw_bytes", dsw, 64'h1716_1514_1312_1110);
        io_write(8'd1, 25'd0, 8'h06);
        io_write(8'd1, 25'd1, 8'h55);
        io_write(8'd3, 25'd0, 8'h77);
        tick(1);
        chk("sysmode", sysmode, 8'h06);

        // Reset mid-stretch with a key held.
        ps2(1'b1, 9'h029);
        coin_pulse();
        chk("pre_reset_player", inp_player, 16'hFFFD);
        chk("pre_reset_sys", inp_sys, 8'hFE);
        reset = 1'b1;
        tick(1);
        chk("rst_player", inp_player, 16'hFFFF);
        chk("rst_sys", inp_sys, 8'hFF);
        reset = 1'b0;
        tick(3);
        chk("post_rst_player", inp_player, 16'hFFFF);
        chk("post_rst_sys", inp_sys, 8'hFF);
        chk("post_rst_sysmode", sysmode, 8'h06);
        chk("post_rst_dsw", dsw, 64'h1716_1514_1312_1110);
        ps2(1'b1, 9'h029);
        tick(2);
        chk("new_event_after_rst", inp_player, 16'hFFFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
